// File: rtl/word_count_accum.sv
// word_count_accum: per-entry {valid, key, count} accumulator behind the
// search/update stage, plus a valid/ready dump port for the host writer.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_addr, in_din   update: entry index (low ADDR_WIDTH bits), {key, increment}
//   in_we             update strobe (no backpressure; dropped + err outside IDLE)
//   dump_kick         start streaming every populated entry
//   clear_kick        zero the whole table (wins over dump_kick)
//   busy              high in CLEAR/DRAIN/DUMP and while updates are in flight
//   err               sticky: update dropped (or count saturated, see below)
//   out_valid/ready   dump record handshake
//   out_addr/key/count dump record payload
//   done              one-cycle pulse at the end of a CLEAR or a DUMP
//
// Build option: define WORD_COUNT_ACCUM_SATURATE_EN to make counts saturate at
// all-ones (and flag err) instead of wrapping.
module word_count_accum #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            in_addr,
  input  logic [63:0]            in_din,
  input  logic                   in_we,
  input  logic                   dump_kick,
  input  logic                   clear_kick,
  output logic                   busy,
  output logic                   err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [31:0]            out_key,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   done
);

  localparam int unsigned DEPTH     = 32'(1) << ADDR_WIDTH;
  localparam int unsigned KEY_WIDTH = 32;
  localparam int unsigned IDX_W     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef struct packed {
    logic                   valid;
    logic [KEY_WIDTH-1:0]   key;
    logic [COUNT_WIDTH-1:0] count;
  } entry_t;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAIN, ST_DUMP} state_t;

  // Upper address bits and upper increment bits are deliberately ignored.
  logic unused_in;
  assign unused_in = ^{in_addr, in_din[31:0]};

  state_t                 state, state_d;
  logic [ADDR_WIDTH-1:0]  clr_idx, clr_idx_d;
  logic [IDX_W-1:0]       dump_rd_idx, dump_rd_idx_d;
  logic                   dump_q_v, dump_q_v_d;
  logic [ADDR_WIDTH-1:0]  dump_q_idx, dump_q_idx_d;

  logic                   s0_v, s0_v_d;
  logic [ADDR_WIDTH-1:0]  s0_idx, s0_idx_d;
  logic [KEY_WIDTH-1:0]   s0_key, s0_key_d;
  logic [COUNT_WIDTH-1:0] s0_inc, s0_inc_d;

  logic                   s1_v, s1_v_d;
  logic [ADDR_WIDTH-1:0]  s1_idx, s1_idx_d;
  logic [KEY_WIDTH-1:0]   s1_key, s1_key_d;
  logic [COUNT_WIDTH-1:0] s1_inc, s1_inc_d;
  logic                   s1_fwd_hit, s1_fwd_hit_d;
  logic                   s1_fwd_ev, s1_fwd_ev_d;
  logic [COUNT_WIDTH-1:0] s1_fwd_cnt, s1_fwd_cnt_d;

  logic                   s2_v, s2_v_d;
  logic [ADDR_WIDTH-1:0]  s2_idx, s2_idx_d;
  entry_t                 s2_word, s2_word_d;

  logic                   busy_d, err_d, done_d;
  logic                   out_valid_d;
  logic [ADDR_WIDTH-1:0]  out_addr_d;
  logic [KEY_WIDTH-1:0]   out_key_d;
  logic [COUNT_WIDTH-1:0] out_count_d;

  logic                   ram_we;
  logic [ADDR_WIDTH-1:0]  ram_waddr, ram_raddr;
  entry_t                 ram_wdata, ram_q;
  entry_t                 mem [DEPTH];

  // Simple dual-port table, read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // S1 merge: newest copy of the entry (S2 write data, then the value captured
  // while S2 was writing during our S0 cycle, then the RAM) plus the increment.
  logic                   old_valid;
  logic [COUNT_WIDTH-1:0] old_cnt, base_cnt, new_cnt;
  logic                   sat_hit;
  entry_t                 s1_new;
`ifdef WORD_COUNT_ACCUM_SATURATE_EN
  logic [COUNT_WIDTH:0]   sum;
`endif

  always_comb begin
    old_valid = ram_q.valid;
    old_cnt   = ram_q.count;
    if (s2_v && (s2_idx == s1_idx)) begin
      old_valid = s2_word.valid;
      old_cnt   = s2_word.count;
    end else if (s1_fwd_hit) begin
      old_valid = s1_fwd_ev;
      old_cnt   = s1_fwd_cnt;
    end
    base_cnt = old_valid ? old_cnt : '0;
`ifdef WORD_COUNT_ACCUM_SATURATE_EN
    sum     = {1'b0, base_cnt} + {1'b0, s1_inc};
    new_cnt = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    sat_hit = s1_v && sum[COUNT_WIDTH];
`else
    new_cnt = base_cnt + s1_inc;
    sat_hit = 1'b0;
`endif
    s1_new = {1'b1, s1_key, new_cnt};
  end

  // Next-state, pipeline advance, RAM port muxing and output next values.
  always_comb begin
    state_d       = state;
    clr_idx_d     = clr_idx;
    dump_rd_idx_d = dump_rd_idx;
    dump_q_v_d    = 1'b0;
    dump_q_idx_d  = dump_q_idx;
    err_d         = err | sat_hit;
    done_d        = 1'b0;
    out_valid_d   = out_valid;
    out_addr_d    = out_addr;
    out_key_d     = out_key;
    out_count_d   = out_count;

    s0_v_d        = 1'b0;
    s0_idx_d      = s0_idx;
    s0_key_d      = s0_key;
    s0_inc_d      = s0_inc;
    s1_v_d        = s0_v;
    s1_idx_d      = s0_idx;
    s1_key_d      = s0_key;
    s1_inc_d      = s0_inc;
    s1_fwd_hit_d  = s2_v && (s2_idx == s0_idx);
    s1_fwd_ev_d   = s2_word.valid;
    s1_fwd_cnt_d  = s2_word.count;
    s2_v_d        = s1_v;
    s2_idx_d      = s1_idx;
    s2_word_d     = s1_new;

    ram_we        = s2_v;
    ram_waddr     = s2_idx;
    ram_wdata     = s2_word;
    ram_raddr     = s0_idx;

    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx;
        ram_wdata = '0;
        clr_idx_d = clr_idx + ADDR_WIDTH'(1);
        if (in_we) err_d = 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          clr_idx_d = '0;
        end
      end
      ST_IDLE: begin
        if (in_we) begin
          s0_v_d   = 1'b1;
          s0_idx_d = in_addr[ADDR_WIDTH-1:0];
          s0_key_d = in_din[63:32];
          s0_inc_d = in_din[COUNT_WIDTH-1:0];
        end
        // In-flight updates are moot once the sweep zeroes everything.
        if (clear_kick) begin
          state_d      = ST_CLEAR;
          clr_idx_d    = '0;
          s0_v_d       = 1'b0;
          s1_v_d       = 1'b0;
          s2_v_d       = 1'b0;
          s1_fwd_hit_d = 1'b0;
        end else if (dump_kick) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_we) err_d = 1'b1;
        if (!(s0_v || s1_v || s2_v)) begin
          state_d       = ST_DUMP;
          dump_rd_idx_d = '0;
        end
      end
      ST_DUMP: begin
        if (in_we) err_d = 1'b1;
        ram_raddr = dump_rd_idx[ADDR_WIDTH-1:0];
        if (out_valid) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (out_addr == LAST_IDX) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          // Stream one read per cycle; a hit cancels the read already issued
          // and rewinds the read pointer to just past the record.
          if (!dump_rd_idx[ADDR_WIDTH]) begin
            dump_q_v_d    = 1'b1;
            dump_q_idx_d  = dump_rd_idx[ADDR_WIDTH-1:0];
            dump_rd_idx_d = dump_rd_idx + IDX_W'(1);
          end
          if (dump_q_v) begin
            if (ram_q.valid) begin
              out_valid_d   = 1'b1;
              out_addr_d    = dump_q_idx;
              out_key_d     = ram_q.key;
              out_count_d   = ram_q.count;
              dump_q_v_d    = 1'b0;
              dump_rd_idx_d = {1'b0, dump_q_idx} + IDX_W'(1);
            end else if (dump_q_idx == LAST_IDX) begin
              state_d    = ST_IDLE;
              done_d     = 1'b1;
              dump_q_v_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    busy_d = (state_d != ST_IDLE) || s0_v_d || s1_v_d || s2_v_d;
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      dump_rd_idx <= '0;
      dump_q_v    <= 1'b0;
      dump_q_idx  <= '0;
      s0_v        <= 1'b0;
      s0_idx      <= '0;
      s0_key      <= '0;
      s0_inc      <= '0;
      s1_v        <= 1'b0;
      s1_idx      <= '0;
      s1_key      <= '0;
      s1_inc      <= '0;
      s1_fwd_hit  <= 1'b0;
      s1_fwd_ev   <= 1'b0;
      s1_fwd_cnt  <= '0;
      s2_v        <= 1'b0;
      s2_idx      <= '0;
      s2_word     <= '0;
      busy        <= 1'b1;
      err         <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_key     <= '0;
      out_count   <= '0;
    end else begin
      state       <= state_d;
      clr_idx     <= clr_idx_d;
      dump_rd_idx <= dump_rd_idx_d;
      dump_q_v    <= dump_q_v_d;
      dump_q_idx  <= dump_q_idx_d;
      s0_v        <= s0_v_d;
      s0_idx      <= s0_idx_d;
      s0_key      <= s0_key_d;
      s0_inc      <= s0_inc_d;
      s1_v        <= s1_v_d;
      s1_idx      <= s1_idx_d;
      s1_key      <= s1_key_d;
      s1_inc      <= s1_inc_d;
      s1_fwd_hit  <= s1_fwd_hit_d;
      s1_fwd_ev   <= s1_fwd_ev_d;
      s1_fwd_cnt  <= s1_fwd_cnt_d;
      s2_v        <= s2_v_d;
      s2_idx      <= s2_idx_d;
      s2_word     <= s2_word_d;
      busy        <= busy_d;
      err         <= err_d;
      done        <= done_d;
      out_valid   <= out_valid_d;
      out_addr    <= out_addr_d;
      out_key     <= out_key_d;
      out_count   <= out_count_d;
    end
  end

endmodule

// File: tb/tb_word_count_accum.sv
// Bench for word_count_accum: a default-size instance for the table/dump flow
// and a narrow (4 entries, 4-bit counts) instance for wrap/saturation.
module tb_word_count_accum;

  localparam int unsigned AW  = 10;
  localparam int unsigned CW  = 32;
  localparam int unsigned NAW = 2;
  localparam int unsigned NCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   in_addr;
  logic [63:0]   in_din;
  logic          in_we, dump_kick, clear_kick, out_ready;
  logic          busy, err, out_valid, done;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_key;
  logic [CW-1:0] out_count;

  logic [31:0]    n_in_addr;
  logic [63:0]    n_in_din;
  logic           n_in_we, n_dump_kick, n_clear_kick, n_out_ready;
  logic           n_busy, n_err, n_out_valid, n_done;
  logic [NAW-1:0] n_out_addr;
  logic [31:0]    n_out_key;
  logic [NCW-1:0] n_out_count;

  word_count_accum #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .in_din(in_din), .in_we(in_we),
    .dump_kick(dump_kick), .clear_kick(clear_kick), .busy(busy), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_key(out_key), .out_count(out_count), .done(done)
  );

  word_count_accum #(.ADDR_WIDTH(NAW), .COUNT_WIDTH(NCW)) u_nar (
    .clk(clk), .reset(reset), .in_addr(n_in_addr), .in_din(n_in_din), .in_we(n_in_we),
    .dump_kick(n_dump_kick), .clear_kick(n_clear_kick), .busy(n_busy), .err(n_err),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_addr(n_out_addr),
    .out_key(n_out_key), .out_count(n_out_count), .done(n_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] key;
    logic [31:0] count;
  } rec_t;

  rec_t exp_q[$];
  rec_t nexp_q[$];
  rec_t m_e, n_e;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] KEY5 = 32'hAAAA_0001;
  localparam logic [31:0] KEY3 = 32'h3333_0003;
  localparam logic [31:0] KEY7 = 32'h7777_0007;
  localparam logic [31:0] KEYN = 32'hBEEF_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] k, input logic [31:0] c);
    rec_t r;
    r.addr = a; r.key = k; r.count = c;
    exp_q.push_back(r);
  endtask

  task automatic push_table();
    push(32'd3, KEY3, 32'd8);
    push(32'd5, KEY5, 32'd4);
    push(32'd7, KEY7, 32'd3);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_all_records"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_dump(input string tag);
    tick();
    dump_kick = 1'b1;
    tick();
    dump_kick = 1'b0;
    wait_done(tag);
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] k, input logic [31:0] inc);
    in_we   = 1'b1;
    in_addr = a;
    in_din  = {k, inc};
    tick();
  endtask

  // Scoreboard monitors: one record popped per accepted handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_record: got addr %0d, expected no record", out_addr);
      end else begin
        m_e = exp_q.pop_front();
        check("rec_addr",  64'(out_addr),  64'(m_e.addr));
        check("rec_key",   64'(out_key),   64'(m_e.key));
        check("rec_count", 64'(out_count), 64'(m_e.count));
      end
    end
  end

  always @(negedge clk) begin
    if (n_out_valid && n_out_ready) begin
      if (nexp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_narrow_record: got addr %0d, expected no record", n_out_addr);
      end else begin
        n_e = nexp_q.pop_front();
        check("nrec_addr",  64'(n_out_addr),  64'(n_e.addr));
        check("nrec_key",   64'(n_out_key),   64'(n_e.key));
        check("nrec_count", 64'(n_out_count), 64'(n_e.count));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  nbusy;
    bit  seen;
    rec_t r;
    logic [31:0] n_exp_cnt;
    logic        n_exp_err;

    reset = 1'b1;
    in_addr = '0; in_din = '0; in_we = 1'b0;
    dump_kick = 1'b0; clear_kick = 1'b0; out_ready = 1'b1;
    n_in_addr = '0; n_in_din = '0; n_in_we = 1'b0;
    n_dump_kick = 1'b0; n_clear_kick = 1'b0; n_out_ready = 1'b1;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",      64'(busy),      64'd1);
    check("rst_err",       64'(err),       64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_out_addr",  64'(out_addr),  64'd0);
    check("rst_out_key",   64'(out_key),   64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);

    // Clear sweep: busy for exactly one cycle per entry, then done.
    nbusy = 0;
    while (busy && nbusy < 2000) begin
      nbusy++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 64'(nbusy), 64'd1024);
    check("clear_done",        64'(done),  64'd1);
    @(negedge clk);
    check("clear_done_pulse",  64'(done),  64'd0);

    // Empty table: no records, still a done pulse.
    run_dump("dump_empty");

    // Four back-to-back updates to one entry, dump kicked with the last one.
    push(32'd5, KEY5, 32'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      in_we = 1'b1; in_addr = 32'd5; in_din = {KEY5, 32'd1};
      if (i == 3) dump_kick = 1'b1;
      tick();
    end
    in_we = 1'b0; dump_kick = 1'b0;
    wait_done("dump_same_idx");

    // Alternating entries with a larger increment in the middle.
    push_table();
    tick();
    upd(32'd3, KEY3, 32'd1);
    upd(32'd7, KEY7, 32'd1);
    upd(32'd3, KEY3, 32'd5);
    upd(32'd7, KEY7, 32'd1);
    upd(32'd3, KEY3, 32'd1);
    upd(32'd7, KEY7, 32'd1);
    upd(32'h8000_0003, KEY3, 32'd1);
    in_we = 1'b0;
    run_dump("dump_alt");

    // Consumer stalls on the first record for ten cycles.
    push_table();
    out_ready = 1'b0;
    tick();
    dump_kick = 1'b1;
    tick();
    dump_kick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_first_valid", 64'(seen), 64'd1);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid_addr", {63'(out_addr), out_valid}, {63'd3, 1'b1});
      check("stall_key_count",  {out_key, out_count},        {KEY3, 32'd8});
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    wait_done("dump_stall");

    // Update during a dump is dropped and flagged.
    check("err_before_drop", 64'(err), 64'd0);
    push_table();
    tick();
    dump_kick = 1'b1;
    tick();
    dump_kick = 1'b0;
    tick();
    tick();
    in_we = 1'b1; in_addr = 32'd5; in_din = {32'h5555_5555, 32'd100};
    tick();
    in_we = 1'b0;
    wait_done("dump_with_drop");
    check("err_after_drop", 64'(err), 64'd1);
    push_table();
    run_dump("redump");
    check("err_sticky", 64'(err), 64'd1);

    // Clear and dump kicked together: clear wins, table ends up empty.
    tick();
    clear_kick = 1'b1; dump_kick = 1'b1;
    tick();
    clear_kick = 1'b0; dump_kick = 1'b0;
    @(negedge clk);
    check("clear_kick_busy", 64'(busy), 64'd1);
    wait_done("clear_kick");
    run_dump("dump_after_clear");

    // Narrow instance: 20 unit increments into a 4-bit count.
`ifdef WORD_COUNT_ACCUM_SATURATE_EN
    n_exp_cnt = 32'd15;
    n_exp_err = 1'b1;
`else
    n_exp_cnt = 32'd4;
    n_exp_err = 1'b0;
`endif
    check("narrow_err_before", 64'(n_err), 64'd0);
    r.addr = 32'd0; r.key = KEYN; r.count = n_exp_cnt;
    nexp_q.push_back(r);
    tick();
    for (int i = 0; i < 20; i++) begin
      n_in_we = 1'b1; n_in_addr = 32'd0; n_in_din = {KEYN, 32'd1};
      tick();
    end
    n_in_we = 1'b0;
    tick();
    n_dump_kick = 1'b1;
    tick();
    n_dump_kick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (n_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("narrow_done",        64'(seen),           64'd1);
    check("narrow_all_records", 64'(nexp_q.size()),  64'd0);
    check("narrow_err",         64'(n_err),          64'(n_exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/word_count_accum.md
Name: word_count_accum

Overview:
- Sits directly downstream of the Axonerve search/update stage. Consumes its accumulate stream: entry address, key value, and increment.
- Keeps a per-entry table of {valid, key value, count} in block RAM. Performs a pipelined read-modify-write at one update per cycle.
- On request, streams every populated entry out to the host-side result writer through a valid/ready interface.

Parameters:
- ADDR_WIDTH, 10, log2 of table depth. 1024 entries; upper bits of in_addr are ignored.
- COUNT_WIDTH, 32, width of each stored count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_addr  input  32  entry address; bits [ADDR_WIDTH-1:0] used
- in_din  input  64  [63:32] key value, [31:0] increment
- in_we  input  1  update strobe; no backpressure
- dump_kick  input  1  pulse: start table dump
- clear_kick  input  1  pulse: zero the table
- busy  output  1  high during CLEAR, DRAIN, DUMP
- err  output  1  sticky: an in_we arrived while not in IDLE
- out_valid  output  1  dump record valid
- out_ready  input  1  dump consumer ready
- out_addr  output  ADDR_WIDTH  entry index of the record
- out_key  output  32  stored key value
- out_count  output  COUNT_WIDTH  stored count
- done  output  1  one-cycle pulse at end of DUMP or CLEAR

Behaviour:
- Table storage:
  - Each word is {valid, key[31:0], count}, held in single-clock simple dual-port RAM with 1-cycle synchronous read.
  - Contents are unknown after configuration. Reset enters CLEAR.
- Reset values: busy=1 (entering CLEAR), err=0, out_valid=0, out_addr=0, out_key=0, out_count=0, done=0. All pipeline valids are 0.
- States: CLEAR, IDLE, DRAIN, DUMP.
- CLEAR:
  - Writes zero words to index 0..2^ADDR_WIDTH-1, one per cycle. The sweep takes 1024 cycles at the default depth.
  - Then pulses done and goes to IDLE.
  - clear_kick in IDLE enters CLEAR; in other states it is ignored.
- IDLE (update pipeline):
  - S0: in_we captures idx, key, inc and issues the RAM read.
  - S1: read data returns.
  - S2:
    - new.count = (old.valid ? old.count : 0) + inc[COUNT_WIDTH-1:0].
    - new.key = key from the update.
    - new.valid = 1.
    - Written the same cycle.
  - Throughput is 1 update/cycle. An update is visible in the table 3 cycles after its in_we.
- Hazard forwarding:
  - If S1's idx equals S2's idx, S1 uses S2's write data instead of the RAM output.
  - If S0's idx equals S2's idx, the S2 value is captured into S1.
  - N back-to-back updates to one index must yield count N*inc.
- Count arithmetic: modulo 2^COUNT_WIDTH (wraps) unless ACCUM_SATURATE_EN is defined.
- dump_kick in IDLE:
  - Enters DRAIN and waits until S0..S2 are empty (max 3 cycles), then enters DUMP at index 0.
  - dump_kick and in_we in the same cycle: the update is accepted first.
- DUMP:
  - Reads indices in ascending order. Entries with valid=0 are skipped, one cycle per entry.
  - Valid entries are presented on the out_* outputs with out_valid=1.
  - Outputs hold stable until the out_valid&&out_ready handshake; then the next index is read.
  - After the last index is consumed or skipped: done pulse, return to IDLE.
  - The table is not modified by a dump.
- in_we in CLEAR, DRAIN or DUMP: the update is dropped and err is set; err is cleared only by reset.
- Simultaneous dump_kick and clear_kick in IDLE: clear wins.
- Reset mid-DUMP or mid-CLEAR:
  - Aborts immediately: out_valid=0, pipeline flushed, new CLEAR started.
- busy=1 in every state except IDLE. When the pipeline is non-empty in IDLE, busy is also 1.

Optional Feature:
- Macro: WORD_COUNT_ACCUM_SATURATE_EN.
- Defined: count additions saturate at 2^COUNT_WIDTH-1. The sticky err flag is also set on the first saturation.
- Undefined: additions wrap modulo 2^COUNT_WIDTH and saturation is not flagged.

Test Plan:
- Reset, then wait: busy=1 for 1024 cycles, then done pulse. A following dump emits no records and pulses done.
- Updates (addr 5, din {32'hAAAA0001, 1}) on 4 consecutive cycles, then dump with out_ready=1 → single record: addr=5, key=32'hAAAA0001, count=4.
- Alternating addr 3/7 for 6 cycles, inc=1, interleaved with addr 3 inc=5 → dump gives addr3 count=8 and addr7 count=3 in ascending order (exercises forwarding from both S1 and S2).
- Dump with out_ready low for 10 cycles on the first record → out_* stable and out_valid held; no record lost or duplicated.
- in_we during DUMP → update dropped, err=1, table unchanged on a re-dump.
- With the saturate macro defined and COUNT_WIDTH=4: 20 updates of inc=1 to addr 0 → count=15, err=1. Without the macro: count=4, err=0.
